// File: rtl/online_result_collector_pkg.sv
// Shared types and helpers for the online multiplier result collector.
// Holds the collector state encoding, result sizing and digit legality.
package online_result_collector_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SKIP    = 2'd1,
      COLLECT = 2'd2,
      HOLD    = 2'd3
   } state_t;

   // Sign bit plus k fraction bits per collected digit.
   function automatic int result_width(input int n, input int rb);
      return 1 + n * (rb - 1);
   endfunction

   function automatic logic digit_legal(input int q, input int r);
      return (q <= r - 1) && (q >= -(r - 1));
   endfunction

endpackage

// File: rtl/online_result_collector_otf_converter.sv
// On-the-fly conversion of an MSD-first signed-digit stream into two's complement.
// Keeps Q and QM = Q - 1 ulp so each step is a shift-and-append, never a carry chain.
module online_result_collector_otf_converter #(
   parameter int width      = 5,
   parameter int radix_bits = 2,
   parameter int radix      = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  init,
   input  logic                  en,
   input  logic [radix_bits-1:0] z,
   output logic [width-1:0]      q_next
);

   localparam int k = radix_bits - 1;
   localparam logic [width-1:0] r_c   = width'(radix);
   localparam logic [width-1:0] one_c = width'(1);

   logic [width-1:0] q_reg, qm_reg;
   logic [width-1:0] base_q, base_qm;
   logic [width-1:0] q_calc, qm_calc, qm_next;
   logic [width-1:0] dig;
   logic             neg, pos;

   // init restarts from Q=0, QM=-1 in the same cycle, so a digit can be converted immediately.
   assign base_q  = init ? '0 : q_reg;
   assign base_qm = init ? '1 : qm_reg;
   assign dig     = width'($signed(z));
   assign neg     = z[radix_bits-1];
   assign pos     = !neg && (|z);

   always_comb begin
      q_calc  = neg ? ((base_qm << k) + r_c + dig) : ((base_q << k) + dig);
      qm_calc = pos ? ((base_q << k) + dig - one_c) : ((base_qm << k) + r_c - one_c + dig);
      q_next  = en ? q_calc  : base_q;
      qm_next = en ? qm_calc : base_qm;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_reg  <= '0;
         qm_reg <= '0;
      end else begin
         q_reg  <= q_next;
         qm_reg <= qm_next;
      end
   end

endmodule

// File: rtl/online_result_collector.sv
// Collects n product digits after the online delay and presents the converted fraction.
// Handshake: result_valid holds with a stable result until a cycle with result_valid & result_ready.
module online_result_collector
   import online_result_collector_pkg::*;
#(
   parameter int no_of_digits = 4,
   parameter int radix_bits   = 2,
   parameter int radix        = 2,
   parameter int delta        = 3
) (
   input  logic                                       clk,
   input  logic                                       reset_n,
   input  logic                                       start,
   input  logic [radix_bits-1:0]                      z,
   output logic [result_width(no_of_digits,radix_bits)-1:0] result,
   output logic                                       result_valid,
   input  logic                                       result_ready,
   output logic                                       digit_err,
   output logic                                       overrun,
   output state_t                                     dbg_state
);

   localparam int res_w = result_width(no_of_digits, radix_bits);
   localparam int cnt_w = $clog2(delta + no_of_digits + 1);
   localparam logic [cnt_w-1:0] delta_c = cnt_w'(delta);
   localparam logic [cnt_w-1:0] last_c  = cnt_w'(delta + no_of_digits - 1);
   localparam logic [cnt_w-1:0] one_c   = cnt_w'(1);

   state_t           state;
   logic [cnt_w-1:0] counter, eff_count;
   logic             handshake, busy, accept_start, overrun_evt;
   logic             sample, last, legal;
   logic [res_w-1:0] q_next;

   always_comb begin
      handshake    = (state == HOLD) && result_valid && result_ready;
      busy         = (state == SKIP) || (state == COLLECT);
      accept_start = start && ((state == IDLE) || busy || handshake);
      overrun_evt  = start && (busy || ((state == HOLD) && !handshake));
      // An accepted start counts as cycle 0; with no online delay it already carries digit 0.
      sample       = accept_start ? (delta == 0)
                                  : (((state == SKIP) && (counter == delta_c)) || (state == COLLECT));
      eff_count    = accept_start ? '0 : counter;
      last         = sample && (eff_count == last_c);
      legal        = digit_legal(int'($signed(z)), radix);
   end

   online_result_collector_otf_converter #(
      .width      (res_w),
      .radix_bits (radix_bits),
      .radix      (radix)
   ) u_otf (
      .clk     (clk),
      .reset_n (reset_n),
      .init    (accept_start),
      .en      (sample),
      .z       (z),
      .q_next  (q_next)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         counter      <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         digit_err    <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (sample && !legal) digit_err <= 1'b1;
         if (overrun_evt)      overrun   <= 1'b1;
         if (last) begin
            result       <= q_next;
            result_valid <= 1'b1;
            state        <= HOLD;
            counter      <= '0;
         end else begin
            if (handshake) result_valid <= 1'b0;
            if (accept_start) begin
               state   <= (delta == 0) ? COLLECT : SKIP;
               counter <= one_c;
            end else if (sample) begin
               state   <= COLLECT;
               counter <= counter + one_c;
            end else if (state == SKIP) begin
               counter <= counter + one_c;
            end else if (handshake) begin
               state   <= IDLE;
            end
         end
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_online_result_collector.sv
// Directed bench for the online result collector: r=2 (delta=3) and r=4 (delta=2) instances.
module tb_online_result_collector;
   import online_result_collector_pkg::*;

   logic       clk, reset_n;
   logic       start_a, ready_a, valid_a, err_a, ovr_a;
   logic [1:0] z_a;
   logic [4:0] result_a;
   state_t     state_a;
   logic       start_b, ready_b, valid_b, err_b, ovr_b;
   logic [2:0] z_b;
   logic [8:0] result_b;
   state_t     state_b;

   logic [8:0] exp_q_a[$];
   logic [8:0] exp_q_b[$];
   int n_checks = 0;
   int n_fail   = 0;

   online_result_collector dut_a (
      .clk(clk), .reset_n(reset_n), .start(start_a), .z(z_a),
      .result(result_a), .result_valid(valid_a), .result_ready(ready_a),
      .digit_err(err_a), .overrun(ovr_a), .dbg_state(state_a)
   );

   online_result_collector #(.no_of_digits(4), .radix_bits(3), .radix(4), .delta(2)) dut_b (
      .clk(clk), .reset_n(reset_n), .start(start_b), .z(z_b),
      .result(result_b), .result_valid(valid_b), .result_ready(ready_b),
      .digit_err(err_b), .overrun(ovr_b), .dbg_state(state_b)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference value: digits weighted by powers of r, then truncated to the result width.
   function automatic logic [8:0] model(input int d0, input int d1, input int d2, input int d3,
                                        input int r, input int w);
      int v;
      int unsigned m;
      v = ((d0 * r + d1) * r + d2) * r + d3;
      m = (32'd1 << w) - 32'd1;
      return 9'(int'(v) & int'(m));
   endfunction

   function automatic int unsigned obs_valid(input int sel);
      return (sel == 0) ? 32'(valid_a) : 32'(valid_b);
   endfunction

   function automatic int unsigned obs_result(input int sel);
      return (sel == 0) ? 32'(result_a) : 32'(result_b);
   endfunction

   // driver tasks
   task automatic drive(input int sel, input logic st, input int zv);
      if (sel == 0) begin
         start_a = st;
         z_a     = 2'(zv);
      end else begin
         start_b = st;
         z_b     = 3'(zv);
      end
   endtask

   task automatic set_ready(input int sel, input logic v);
      if (sel == 0) ready_a = v;
      else          ready_b = v;
   endtask

   task automatic run_op(input string tag, input int sel, input int d0, input int d1,
                         input int d2, input int d3);
      int dl, r, w;
      int d[4];
      dl = (sel == 0) ? 3 : 2;
      r  = (sel == 0) ? 2 : 4;
      w  = (sel == 0) ? 5 : 9;
      d  = '{d0, d1, d2, d3};
      if (sel == 0) exp_q_a.push_back(model(d0, d1, d2, d3, r, w));
      else          exp_q_b.push_back(model(d0, d1, d2, d3, r, w));
      drive(sel, 1'b1, 0);
      tick();
      // Skipped cycles carry an illegal digit: it must not be flagged.
      for (int i = 1; i < dl; i++) begin
         drive(sel, 1'b0, -r);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         drive(sel, 1'b0, d[i]);
         if (i == 0) check({tag, "_valid_at_d0"}, obs_valid(sel), 0);
         if (i == 3) check({tag, "_valid_before_last"}, obs_valid(sel), 0);
         tick();
      end
      drive(sel, 1'b0, 0);
   endtask

   // scoreboard pop at the cycle the result is due
   task automatic expect_result(input string tag, input int sel);
      logic [8:0] e;
      check({tag, "_valid"}, obs_valid(sel), 1);
      n_checks++;
      if (((sel == 0) ? exp_q_a.size() : exp_q_b.size()) == 0) begin
         n_fail++;
         $error("FAIL %s_sb observed=result expected=queued_entry", tag);
      end else begin
         e = (sel == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
         assert (obs_result(sel) === 32'(e)) else begin
            n_fail++;
            $error("FAIL %s_result observed=%0h expected=%0h", tag, obs_result(sel), e);
         end
      end
   endtask

   task automatic handshake(input string tag, input int sel);
      set_ready(sel, 1'b1);
      tick();
      set_ready(sel, 1'b0);
      check({tag, "_valid_drop"}, obs_valid(sel), 0);
   endtask

   initial begin
      reset_n = 1'b0;
      start_a = 1'b0; z_a = '0; ready_a = 1'b0;
      start_b = 1'b0; z_b = '0; ready_b = 1'b0;
      tick(); tick();
      check("rst_result_a", 32'(result_a), 0);
      check("rst_valid_a", 32'(valid_a), 0);
      check("rst_err_a", 32'(err_a), 0);
      check("rst_ovr_a", 32'(ovr_a), 0);
      check("rst_state_a", 32'(state_a), 32'(IDLE));
      check("rst_result_b", 32'(result_b), 0);
      reset_n = 1'b1;
      tick();

      // 1: 1,0,-1,1 -> 7/16
      run_op("t1", 0, 1, 0, -1, 1);
      expect_result("t1", 0);
      check("t1_const", 32'(result_a), 32'h07);
      check("t1_err", 32'(err_a), 0);
      check("t1_ovr", 32'(ovr_a), 0);
      handshake("t1", 0);

      // 2: -1 x4 -> -15/16, held through a stall; a start in HOLD is ignored
      run_op("t2", 0, -1, -1, -1, -1);
      expect_result("t2", 0);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) drive(0, 1'b1, 0);
         tick();
         drive(0, 1'b0, 0);
         check("t2_stall_valid", 32'(valid_a), 1);
         check("t2_stall_result", 32'(result_a), 32'h11);
      end
      check("t2_hold_ovr", 32'(ovr_a), 1);
      check("t2_state_hold", 32'(state_a), 32'(HOLD));
      handshake("t2", 0);
      check("t2_state_idle", 32'(state_a), 32'(IDLE));

      // 3: r=4, delta=2: 3,-3,0,2 -> 146/256
      run_op("t3", 1, 3, -3, 0, 2);
      expect_result("t3", 1);
      check("t3_const", 32'(result_b), 32'h092);
      check("t3_err", 32'(err_b), 0);
      handshake("t3", 1);

      // 4: illegal digit 2'b10 at digit 1, sticky across a clean operation
      run_op("t4a", 0, 1, -2, 0, 1);
      expect_result("t4a", 0);
      check("t4_err_set", 32'(err_a), 1);
      handshake("t4a", 0);
      run_op("t4b", 0, 1, 0, -1, 1);
      expect_result("t4b", 0);
      check("t4_err_sticky", 32'(err_a), 1);
      handshake("t4b", 0);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      check("t4_err_cleared", 32'(err_a), 0);
      check("t4_ovr_cleared", 32'(ovr_a), 0);

      // 5: second start at cycle 4 aborts the first; result of the second at cycle 11
      drive(0, 1'b1, 0); tick();
      drive(0, 1'b0, -2); tick();
      drive(0, 1'b0, -2); tick();
      drive(0, 1'b0, 1);  tick();
      run_op("t5", 0, 0, 1, 1, -1);
      expect_result("t5", 0);
      check("t5_ovr", 32'(ovr_a), 1);
      handshake("t5", 0);

      // 6: asynchronous reset mid-COLLECT, then a fresh operation
      drive(0, 1'b1, 0); tick();
      drive(0, 1'b0, 0); tick();
      tick();
      drive(0, 1'b0, 1); tick();
      drive(0, 1'b0, 0); tick();
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_rst_result", 32'(result_a), 0);
      check("t6_rst_valid", 32'(valid_a), 0);
      check("t6_rst_ovr", 32'(ovr_a), 0);
      check("t6_rst_state", 32'(state_a), 32'(IDLE));
      tick();
      reset_n = 1'b1;
      tick();
      run_op("t6", 0, 1, 0, -1, 1);
      expect_result("t6", 0);
      handshake("t6", 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
